// File: rtl/tube_pkg.sv
// Shared constants and Gray-code helpers for the Tube host/parasite FIFOs.
package tube_pkg;

  localparam int         HP_DEPTH    = 2;
  localparam int         HP_PTR_W    = 2;
  localparam logic [7:0] HP_DATA_RST = 8'h00;

  function automatic logic [HP_PTR_W-1:0] bin2gray(input logic [HP_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [HP_PTR_W-1:0] gray2bin(input logic [HP_PTR_W-1:0] g);
    logic [HP_PTR_W-1:0] b;
    b[HP_PTR_W-1] = g[HP_PTR_W-1];
    for (int i = HP_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/tube_sync2.sv
// Two-flop synchroniser for Gray-coded pointers; NEG_EDGE selects the capture edge.
module tube_sync2 #(
  parameter int PTR_W    = 2,
  parameter bit NEG_EDGE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic [PTR_W-1:0] d_i,
  output logic [PTR_W-1:0] q_o
);

  logic [PTR_W-1:0] meta_q;
  logic [PTR_W-1:0] sync_q;

  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
          meta_q <= '0;
          sync_q <= '0;
        end else begin
          meta_q <= d_i;
          sync_q <= meta_q;
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
          meta_q <= '0;
          sync_q <= '0;
        end else begin
          meta_q <= d_i;
          sync_q <= meta_q;
        end
      end
    end
  endgenerate

  assign q_o = sync_q;

endmodule

// File: rtl/hp_fifo2.sv
// Two-entry host-to-parasite byte FIFO crossing h_phi2 (negedge) to p_clk (posedge).
// Optional parasite NMI on a full two-byte block: define TUBE_HP_NMI_EN.
module hp_fifo2
  import tube_pkg::*;
(
  input  logic       h_phi2,
  input  logic       h_rst_b,
  input  logic       p_clk,
  input  logic       h_selectData,
  input  logic       h_rd,
  input  logic [7:0] h_data,
  output logic       h_full,
  input  logic       p_selectData,
  input  logic       p_rd,
  output logic [7:0] p_data,
  output logic       p_data_available,
  output logic       p_nmi
);

  logic [7:0]          mem_q [0:HP_DEPTH-1];
  logic [HP_PTR_W-1:0] wptr_q, wptr_d, wptrG_q;
  logic [HP_PTR_W-1:0] rptr_q, rptr_d, rptrG_q;
  logic [HP_PTR_W-1:0] wptrSyncG, rptrSyncG;
  logic [HP_PTR_W-1:0] hOcc, pOcc;
  logic                hPush, pPop;

  always_comb begin
    hPush  = h_selectData & ~h_rd & ~h_full;
    wptr_d = hPush ? wptr_q + 2'd1 : wptr_q;
    pPop   = p_selectData & p_rd & p_data_available;
    rptr_d = pPop ? rptr_q + 2'd1 : rptr_q;
  end

  // Gray copies are registered so the synchronisers never see a decode glitch.
  always_ff @(negedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      for (int i = 0; i < HP_DEPTH; i++) mem_q[i] <= HP_DATA_RST;
      wptr_q  <= '0;
      wptrG_q <= '0;
    end else begin
      if (hPush) mem_q[wptr_q[0]] <= h_data;
      wptr_q  <= wptr_d;
      wptrG_q <= bin2gray(wptr_d);
    end
  end

  always_ff @(posedge p_clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      rptr_q  <= '0;
      rptrG_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      rptrG_q <= bin2gray(rptr_d);
    end
  end

  tube_sync2 #(.PTR_W(HP_PTR_W), .NEG_EDGE(1'b0)) u_wptrSync (
    .clk_i   (p_clk),
    .rst_b_i (h_rst_b),
    .d_i     (wptrG_q),
    .q_o     (wptrSyncG)
  );

  tube_sync2 #(.PTR_W(HP_PTR_W), .NEG_EDGE(1'b1)) u_rptrSync (
    .clk_i   (h_phi2),
    .rst_b_i (h_rst_b),
    .d_i     (rptrG_q),
    .q_o     (rptrSyncG)
  );

  // Each side compares its own live pointer with a stale copy of the other,
  // so both flags can only err on the safe side.
  assign hOcc             = wptr_q - gray2bin(rptrSyncG);
  assign pOcc             = gray2bin(wptrSyncG) - rptr_q;
  assign h_full           = (hOcc == HP_PTR_W'(HP_DEPTH));
  assign p_data_available = (pOcc != '0);
  assign p_data           = mem_q[rptr_q[0]];

`ifdef TUBE_HP_NMI_EN
  assign p_nmi = (pOcc == HP_PTR_W'(HP_DEPTH));
`else
  assign p_nmi = 1'b0;
`endif

endmodule

// File: tb/tb_hp_fifo2.sv
// Scoreboard bench for hp_fifo2: directed fill/wrap/reset cases plus random
// concurrent traffic at two parasite clock rates.
module tb_hp_fifo2;

  logic       h_phi2 = 1'b0;
  logic       h_rst_b = 1'b0;
  logic       p_clk = 1'b0;
  logic       h_selectData = 1'b0;
  logic       h_rd = 1'b0;
  logic [7:0] h_data = 8'h00;
  logic       p_selectData = 1'b0;
  logic       p_rd = 1'b0;
  logic       h_full;
  logic [7:0] p_data;
  logic       p_data_available;
  logic       p_nmi;

  int         pHalf = 167;
  int         vecCount = 0;
  int         missCount = 0;
  int         cyc;
  logic [7:0] expQ [$];

`ifdef TUBE_HP_NMI_EN
  localparam bit NMI_EN = 1'b1;
`else
  localparam bit NMI_EN = 1'b0;
`endif

  hp_fifo2 dut (
    .h_phi2           (h_phi2),
    .h_rst_b          (h_rst_b),
    .p_clk            (p_clk),
    .h_selectData     (h_selectData),
    .h_rd             (h_rd),
    .h_data           (h_data),
    .h_full           (h_full),
    .p_selectData     (p_selectData),
    .p_rd             (p_rd),
    .p_data           (p_data),
    .p_data_available (p_data_available),
    .p_nmi            (p_nmi)
  );

  // 2 MHz host clock; the parasite clock is offset so its edges avoid the host edges.
  initial forever #250 h_phi2 = ~h_phi2;
  initial begin
    #4;
    forever #pHalf p_clk = ~p_clk;
  end

  initial begin
    #50000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit accepted);
    @(posedge h_phi2);
    #1;
    h_selectData = 1'b1;
    h_rd         = 1'b0;
    h_data       = d;
    @(negedge h_phi2);
    #1;
    h_selectData = 1'b0;
    if (accepted) expQ.push_back(d);
  endtask

  task automatic waitAvail(input int limit, output int cycles);
    cycles = 0;
    while (!p_data_available && cycles < limit) begin
      @(posedge p_clk);
      #1;
      cycles++;
    end
  endtask

  task automatic waitFullClear(input int limit, output int cycles);
    cycles = 0;
    while (h_full && cycles < limit) begin
      @(negedge h_phi2);
      #1;
      cycles++;
    end
  endtask

  task automatic parasitePop(input string tag);
    logic [8:0] e;
    @(negedge p_clk);
    checkOutput({tag, "_avail"}, 32'(p_data_available), 32'd1);
    if (expQ.size() != 0) e = {1'b1, expQ.pop_front()};
    else                  e = 9'h000;
    checkOutput({tag, "_data"}, 32'({1'b1, p_data}), 32'(e));
    p_selectData = 1'b1;
    p_rd         = 1'b1;
    @(negedge p_clk);
    p_selectData = 1'b0;
    p_rd         = 1'b0;
  endtask

  task automatic runRandom(input int nBytes, input string tag);
    int got;
    int budget;
    got    = 0;
    budget = 0;
    fork
      begin
        for (int i = 0; i < nBytes; i++) begin
          logic [7:0] d;
          int tries;
          d     = 8'($urandom);
          tries = 0;
          repeat ($urandom_range(0, 2)) @(posedge h_phi2);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge h_phi2);
            #1;
            h_selectData = 1'b1;
            h_rd         = 1'b1;
            @(negedge h_phi2);
            #1;
            h_selectData = 1'b0;
            h_rd         = 1'b0;
          end
          @(posedge h_phi2);
          #1;
          while (h_full && tries < 200) begin
            @(posedge h_phi2);
            #1;
            tries++;
          end
          h_selectData = 1'b1;
          h_rd         = 1'b0;
          h_data       = d;
          @(negedge h_phi2);
          #1;
          h_selectData = 1'b0;
          expQ.push_back(d);
        end
      end
      begin
        while (got < nBytes && budget < 40000) begin
          logic [8:0] e;
          @(negedge p_clk);
          budget++;
          p_selectData = 1'b0;
          p_rd         = 1'b0;
          if (p_data_available && $urandom_range(0, 2) != 0) begin
            if (expQ.size() != 0) e = {1'b1, expQ.pop_front()};
            else                  e = 9'h000;
            checkOutput({tag, "_data"}, 32'({1'b1, p_data}), 32'(e));
            p_selectData = 1'b1;
            p_rd         = 1'b1;
            got++;
          end
        end
        @(negedge p_clk);
        p_selectData = 1'b0;
        p_rd         = 1'b0;
      end
    join
    checkOutput({tag, "_count"}, 32'(got), 32'(nBytes));
    checkOutput({tag, "_leftover"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    // Power-on reset values.
    #100;
    checkOutput("rst_full",  32'(h_full),           32'd0);
    checkOutput("rst_avail", 32'(p_data_available), 32'd0);
    checkOutput("rst_nmi",   32'(p_nmi),            32'd0);
    checkOutput("rst_data",  32'(p_data),           32'h00);
    #600;
    h_rst_b = 1'b1;

    // Single byte.
    applyStimulus(8'hA5, 1'b1);
    waitAvail(4, cyc);
    checkOutput("a5_latency", 32'(p_data_available && cyc <= 3), 32'd1);
    checkOutput("a5_nmi", 32'(p_nmi), 32'd0);
    parasitePop("a5");
    checkOutput("a5_empty", 32'(p_data_available), 32'd0);
    checkOutput("a5_full", 32'(h_full), 32'd0);
    repeat (4) @(negedge h_phi2);

    // Fill and overflow.
    applyStimulus(8'h11, 1'b1);
    checkOutput("fill_full1", 32'(h_full), 32'd0);
    applyStimulus(8'h22, 1'b1);
    checkOutput("fill_full2", 32'(h_full), 32'd1);
    applyStimulus(8'h33, 1'b0);
    checkOutput("fill_full3", 32'(h_full), 32'd1);
    waitAvail(4, cyc);
    repeat (3) @(posedge p_clk);
    #1;
    checkOutput("fill_nmi2", 32'(p_nmi), 32'(NMI_EN));
    parasitePop("fill1");
    checkOutput("fill_nmi1", 32'(p_nmi), 32'd0);
    waitFullClear(4, cyc);
    checkOutput("fill_release", 32'(!h_full && cyc <= 3), 32'd1);
    parasitePop("fill2");
    checkOutput("fill_empty", 32'(p_data_available), 32'd0);
    repeat (4) @(negedge h_phi2);

    // Wrap-around, one byte at a time.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(8'(i), 1'b1);
      checkOutput("wrap_full", 32'(h_full), 32'd0);
      waitAvail(4, cyc);
      checkOutput("wrap_latency", 32'(p_data_available && cyc <= 3), 32'd1);
      checkOutput("wrap_nmi", 32'(p_nmi), 32'd0);
      parasitePop("wrap");
      checkOutput("wrap_empty", 32'(p_data_available), 32'd0);
      repeat (4) @(negedge h_phi2);
    end

    // Reset while a byte is held and another write is on the bus.
    applyStimulus(8'h5A, 1'b1);
    waitAvail(4, cyc);
    @(posedge h_phi2);
    #1;
    h_selectData = 1'b1;
    h_rd         = 1'b0;
    h_data       = 8'hC3;
    #100;
    h_rst_b = 1'b0;
    #1;
    checkOutput("midrst_full",  32'(h_full),           32'd0);
    checkOutput("midrst_avail", 32'(p_data_available), 32'd0);
    checkOutput("midrst_nmi",   32'(p_nmi),            32'd0);
    checkOutput("midrst_data",  32'(p_data),           32'h00);
    h_selectData = 1'b0;
    expQ.delete();
    #50;
    h_rst_b = 1'b1;
    repeat (4) @(negedge p_clk);
    checkOutput("postrst_avail", 32'(p_data_available), 32'd0);

    // Concurrent traffic at two unrelated clock ratios.
    runRandom(200, "rnd3m");
    repeat (4) @(negedge h_phi2);
    pHalf = 10;
    repeat (4) @(negedge h_phi2);
    runRandom(200, "rnd50m");
    checkOutput("end_nmi", 32'(p_nmi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
